// File: rtl/alu_cmd_sequencer_if.sv
// Signal bundle between the command source / ALU side (master) and alu_cmd_sequencer (slave).
interface alu_cmd_sequencer_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [3:0]             cmd_op;
   logic [WIDTH-1:0]       cmd_p;
   logic [WIDTH-1:0]       cmd_q;
   logic [WIDTH-1:0]       alu_p;
   logic [WIDTH-1:0]       alu_q;
   logic [3:0]             alu_op;
   logic [WIDTH-1:0]       alu_out;
   logic [1:0]             alu_err;
   logic                   res_valid;
   logic                   res_ready;
   logic [WIDTH-1:0]       res_data;
   logic [1:0]             res_err;
   logic [3:0]             res_op;
   logic                   busy;
   logic [$clog2(DEPTH):0] fifo_count;
   logic [7:0]             err_count;

   modport master (
      output cmd_valid, cmd_op, cmd_p, cmd_q, alu_out, alu_err, res_ready,
      input  cmd_ready, alu_p, alu_q, alu_op, res_valid, res_data, res_err, res_op,
             busy, fifo_count, err_count
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_p, cmd_q, alu_out, alu_err, res_ready,
      output cmd_ready, alu_p, alu_q, alu_op, res_valid, res_data, res_err, res_op,
             busy, fifo_count, err_count
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// ALU issue stage: command FIFO, one-at-a-time issue, held result with valid/ready.
// Optional macro ERR_FLUSH_EN: an erroring result flushes the queued commands.
//
// state | meaning
// IDLE  | no command in flight; ALU held on feedback opcode
// ISSUE | command on ALU inputs; result captured at closing edge
// HOLD  | result presented, waiting for res_ready
module alu_cmd_sequencer #(
   parameter int         WIDTH   = 32,
   parameter int         DEPTH   = 4,
   parameter logic [3:0] HOLD_OP = 4'b1110
) (
   input logic               clk,
   input logic               rst,
   alu_cmd_sequencer_if.slave bus
);
   localparam int         PW         = $clog2(DEPTH);
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);
   localparam logic [3:0] RESET_OP   = 4'b1100;

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} seqState_t;

   seqState_t        state;
   logic [3:0]       fifoOp [DEPTH];
   logic [WIDTH-1:0] fifoP  [DEPTH];
   logic [WIDTH-1:0] fifoQ  [DEPTH];
   logic [PW-1:0]    wrPtr;
   logic [PW-1:0]    rdPtr;
   logic [PW:0]      count;
   logic             cmdReady;
   logic             notEmpty;
   logic             push;
   logic             pop;
   logic             flush;

   logic [WIDTH-1:0] aluP;
   logic [WIDTH-1:0] aluQ;
   logic [3:0]       aluOp;
   logic             resValid;
   logic [WIDTH-1:0] resData;
   logic [1:0]       resErr;
   logic [3:0]       resOp;
   logic [7:0]       errCount;

   assign cmdReady = (count != FULL_COUNT);
   assign notEmpty = (count != '0);
   assign push     = bus.cmd_valid && cmdReady;
   assign pop      = notEmpty && ((state == IDLE) || ((state == HOLD) && bus.res_ready));

`ifdef ERR_FLUSH_EN
   assign flush = (state == ISSUE) && (bus.alu_err != 2'b00);
`else
   assign flush = 1'b0;
`endif

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         fifoOp[wrPtr] <= bus.cmd_op;
         fifoP[wrPtr]  <= bus.cmd_p;
         fifoQ[wrPtr]  <= bus.cmd_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else if (flush) begin
         rdPtr <= wrPtr;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         aluP     <= '0;
         aluQ     <= '0;
         aluOp    <= RESET_OP;
         resValid <= 1'b0;
         resData  <= '0;
         resErr   <= 2'b00;
         resOp    <= 4'b0000;
         errCount <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  aluP  <= fifoP[rdPtr];
                  aluQ  <= fifoQ[rdPtr];
                  aluOp <= fifoOp[rdPtr];
                  state <= ISSUE;
               end else begin
                  aluOp <= HOLD_OP;
               end
            end
            ISSUE: begin
               resData  <= bus.alu_out;
               resErr   <= bus.alu_err;
               resOp    <= aluOp;
               resValid <= 1'b1;
               if ((bus.alu_err != 2'b00) && (errCount != 8'hFF))
                  errCount <= errCount + 8'd1;
               aluOp <= HOLD_OP;
               state <= HOLD;
            end
            HOLD: begin
               aluOp <= HOLD_OP;
               if (bus.res_ready) begin
                  resValid <= 1'b0;
                  if (pop) begin
                     aluP  <= fifoP[rdPtr];
                     aluQ  <= fifoQ[rdPtr];
                     aluOp <= fifoOp[rdPtr];
                     state <= ISSUE;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready  = cmdReady;
   assign bus.alu_p      = aluP;
   assign bus.alu_q      = aluQ;
   assign bus.alu_op     = aluOp;
   assign bus.res_valid  = resValid;
   assign bus.res_data   = resData;
   assign bus.res_err    = resErr;
   assign bus.res_op     = resOp;
   assign bus.busy       = (state != IDLE) || notEmpty;
   assign bus.fifo_count = count;
   assign bus.err_count  = errCount;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU (accumulator feedback) model.
module tb_alu_cmd_sequencer;
   localparam int         WIDTH    = 32;
   localparam int         DEPTH    = 4;
   localparam logic [3:0] HOLD_OP  = 4'b1110;
   localparam logic [3:0] RESET_OP = 4'b1100;

   typedef struct packed { logic [31:0] out; logic [1:0] err; } aluRes_t;
   typedef struct { logic [3:0] op; logic [31:0] p; logic [31:0] q; } cmd_t;
   typedef struct {
      logic [3:0]  op;
      logic [31:0] p;
      logic [31:0] q;
      logic [31:0] expData;
      logic [1:0]  expErr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] acc = 32'h0000_1234;
   aluRes_t     aluRes;
   int          nCompared = 0;
   int          nMismatched = 0;

   vec_t        vecs [12];
   cmd_t        bpCmd [6];
   logic [31:0] bpExp [5];
   logic [3:0]  opsList [9];

   alu_cmd_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_OP(HOLD_OP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // ALU: non-zero accumulator replaces Q; 0011 divides Q by P.
   function automatic aluRes_t aluEval(input logic [3:0] op, input logic [31:0] p,
                                       input logic [31:0] q, input logic [31:0] accIn);
      aluRes_t     r;
      logic [31:0] qe;
      logic [32:0] s;
      qe    = (accIn != 32'd0) ? accIn : q;
      r.out = 32'd0;
      r.err = 2'b00;
      case (op)
         4'b0000: begin
            s     = {1'b0, p} + {1'b0, qe};
            r.out = s[31:0];
            r.err = s[32] ? 2'b10 : 2'b00;
         end
         4'b0001: r.out = p - qe;
         4'b0010: r.out = p * qe;
         4'b0011: begin
            if (p == 32'd0) r.err = 2'b01;
            else            r.out = qe / p;
         end
         4'b0100: r.out = p & qe;
         4'b0101: r.out = p | qe;
         4'b0110: r.out = p ^ qe;
         4'b1100: r.out = 32'd0;
         4'b1101: r.out = p;
         4'b1110: r.out = accIn;
         default: r.out = 32'd0;
      endcase
      return r;
   endfunction

   always_comb aluRes = aluEval(bus.alu_op, bus.alu_p, bus.alu_q, acc);
   assign bus.alu_out = aluRes.out;
   assign bus.alu_err = aluRes.err;
   always @(posedge clk) acc <= aluRes.out;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic doReset();
      rst = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic fillFive(output int nAcc);
      int   guard;
      logic acceptNow;
      nAcc  = 0;
      guard = 0;
      bus.res_ready = 1'b0;
      while (nAcc < 5 && guard < 20) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_op    = bpCmd[nAcc].op;
         bus.cmd_p     = bpCmd[nAcc].p;
         bus.cmd_q     = bpCmd[nAcc].q;
         acceptNow     = bus.cmd_ready;
         step();
         if (acceptNow) nAcc++;
         guard++;
      end
      bus.cmd_valid = 1'b0;
   endtask

   initial begin
      int          nAcc;
      int          nRes;
      int          expRes;
      int          expCnt;
      int          seen;
      int          guard;
      logic [31:0] gotData [8];
      logic [1:0]  gotErr  [8];
      logic        errSeen;
      logic        acceptNow;
      logic        prevHeld;
      logic [31:0] prevData;
      logic [3:0]  prevOp;
      logic [1:0]  prevErr;
      logic [31:0] refAcc;
      aluRes_t     exp;
      cmd_t        c;
      cmd_t        pending [$];

      vecs[0]  = '{4'b0000, 32'd5,          32'd3,    32'd8,   2'b00};
      vecs[1]  = '{4'b0010, 32'd2,          32'd99,   32'd16,  2'b00};
      vecs[2]  = '{4'b0001, 32'd20,         32'd0,    32'd4,   2'b00};
      vecs[3]  = '{4'b1100, 32'd0,          32'd0,    32'd0,   2'b00};
      vecs[4]  = '{4'b0011, 32'd0,          32'd7,    32'd0,   2'b01};
      vecs[5]  = '{4'b0011, 32'd3,          32'd30,   32'd10,  2'b00};
      vecs[6]  = '{4'b0000, 32'hFFFF_FFFF,  32'd0,    32'd9,   2'b10};
      vecs[7]  = '{4'b1101, 32'd77,         32'd5,    32'd77,  2'b00};
      vecs[8]  = '{4'b1110, 32'd1,          32'd2,    32'd77,  2'b00};
      vecs[9]  = '{4'b0110, 32'h0000_00F0,  32'd0,    32'hBD,  2'b00};
      vecs[10] = '{4'b1100, 32'd11,         32'd12,   32'd0,   2'b00};
      vecs[11] = '{4'b0100, 32'h0000_00FF,  32'h3C,   32'h3C,  2'b00};

      bpCmd[0] = '{4'b0000, 32'd1,  32'd2};
      bpCmd[1] = '{4'b0000, 32'd10, 32'd0};
      bpCmd[2] = '{4'b0001, 32'd20, 32'd0};
      bpCmd[3] = '{4'b0010, 32'd3,  32'd0};
      bpCmd[4] = '{4'b1101, 32'd42, 32'd0};
      bpCmd[5] = '{4'b0000, 32'd99, 32'd0};
      bpExp[0] = 32'd3;  bpExp[1] = 32'd13; bpExp[2] = 32'd7;
      bpExp[3] = 32'd21; bpExp[4] = 32'd42;

      opsList[0] = 4'b0001; opsList[1] = 4'b0010; opsList[2] = 4'b0011;
      opsList[3] = 4'b0100; opsList[4] = 4'b0101; opsList[5] = 4'b0110;
      opsList[6] = 4'b1100; opsList[7] = 4'b1101; opsList[8] = 4'b1110;

      // Reset values
      rst = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_op = 4'b0000; bus.cmd_p = 32'd0; bus.cmd_q = 32'd0;
      bus.res_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_alu_op",     32'(bus.alu_op), 32'(RESET_OP));
      check("rst_alu_p",      bus.alu_p, 32'd0);
      check("rst_alu_q",      bus.alu_q, 32'd0);
      check("rst_res_valid",  32'(bus.res_valid), 32'd0);
      check("rst_res_data",   bus.res_data, 32'd0);
      check("rst_res_op",     32'(bus.res_op), 32'd0);
      check("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
      check("rst_cmd_ready",  32'(bus.cmd_ready), 32'd1);
      check("rst_err_count",  32'(bus.err_count), 32'd0);
      check("rst_busy",       32'(bus.busy), 32'd0);
      check("rst_acc_clear",  acc, 32'd0);
      rst = 1'b0;
      step();
      check("idle_alu_op", 32'(bus.alu_op), 32'(HOLD_OP));

      // Table: one command at a time, latency and result
      bus.res_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_op = vecs[i].op; bus.cmd_p = vecs[i].p; bus.cmd_q = vecs[i].q;
         step();
         bus.cmd_valid = 1'b0;
         check($sformatf("tbl%0d_count", i), 32'(bus.fifo_count), 32'd1);
         check($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'd1);
         step();
         check($sformatf("tbl%0d_issue_op", i), 32'(bus.alu_op), 32'(vecs[i].op));
         check($sformatf("tbl%0d_issue_p", i), bus.alu_p, vecs[i].p);
         check($sformatf("tbl%0d_issue_q", i), bus.alu_q, vecs[i].q);
         check($sformatf("tbl%0d_issue_rv", i), 32'(bus.res_valid), 32'd0);
         step();
         check($sformatf("tbl%0d_rv", i), 32'(bus.res_valid), 32'd1);
         check($sformatf("tbl%0d_data", i), bus.res_data, vecs[i].expData);
         check($sformatf("tbl%0d_err", i), 32'(bus.res_err), 32'(vecs[i].expErr));
         check($sformatf("tbl%0d_res_op", i), 32'(bus.res_op), 32'(vecs[i].op));
         check($sformatf("tbl%0d_hold_op", i), 32'(bus.alu_op), 32'(HOLD_OP));
         step();
         check($sformatf("tbl%0d_rv_drop", i), 32'(bus.res_valid), 32'd0);
      end
      check("tbl_err_count", 32'(bus.err_count), 32'd2);

      // Backpressure: fill to DEPTH with one result held, then drain back-to-back
      doReset();
      fillFive(nAcc);
      check("bp_accepted", nAcc, 32'd5);
      bus.cmd_valid = 1'b1;
      bus.cmd_op = bpCmd[5].op; bus.cmd_p = bpCmd[5].p; bus.cmd_q = bpCmd[5].q;
      check("bp_full_count", 32'(bus.fifo_count), 32'd4);
      check("bp_full_ready", 32'(bus.cmd_ready), 32'd0);
      check("bp_held_rv",    32'(bus.res_valid), 32'd1);
      repeat (3) step();
      check("bp_held_data",  bus.res_data, bpExp[0]);
      check("bp_held_count", 32'(bus.fifo_count), 32'd4);
      bus.res_ready = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
      check("bp_refused_push", 32'(bus.fifo_count), 32'd3);
      for (int i = 1; i < 5; i++) begin
         check($sformatf("bp%0d_issue_rv", i), 32'(bus.res_valid), 32'd0);
         step();
         check($sformatf("bp%0d_rv", i), 32'(bus.res_valid), 32'd1);
         check($sformatf("bp%0d_data", i), bus.res_data, bpExp[i]);
         check($sformatf("bp%0d_op", i), 32'(bus.res_op), 32'(bpCmd[i].op));
         step();
      end
      check("bp_end_busy",  32'(bus.busy), 32'd0);
      check("bp_end_count", 32'(bus.fifo_count), 32'd0);

      // Error result with two commands queued behind it
      doReset();
      bus.res_ready = 1'b1;
      bpCmd[0] = '{4'b1100, 32'd0, 32'd0};
      bpCmd[1] = '{4'b0011, 32'd0, 32'd7};
      bpCmd[2] = '{4'b0000, 32'd1, 32'd1};
      bpCmd[3] = '{4'b0000, 32'd2, 32'd2};
      nAcc = 0; nRes = 0; errSeen = 1'b0;
`ifdef ERR_FLUSH_EN
      expRes = 2; expCnt = 0;
`else
      expRes = 4; expCnt = 2;
`endif
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (bus.res_valid) begin
            if (nRes < 8) begin
               gotData[nRes] = bus.res_data;
               gotErr[nRes]  = bus.res_err;
            end
            nRes++;
            if (bus.res_err == 2'b01 && !errSeen) begin
               errSeen = 1'b1;
               check("err_capture_count", 32'(bus.fifo_count), expCnt);
            end
         end
         if (nAcc < 4) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op = bpCmd[nAcc].op; bus.cmd_p = bpCmd[nAcc].p; bus.cmd_q = bpCmd[nAcc].q;
         end else begin
            bus.cmd_valid = 1'b0;
         end
         acceptNow = bus.cmd_valid && bus.cmd_ready;
         step();
         if (acceptNow) nAcc++;
      end
      check("err_accepted",  nAcc, 32'd4);
      check("err_seen",      32'(errSeen), 32'd1);
      check("err_n_results", nRes, expRes);
      check("err_err_count", 32'(bus.err_count), 32'd1);
      if (nRes >= 2) begin
         check("err_r0_data", gotData[0], 32'd0);
         check("err_r0_err",  32'(gotErr[0]), 32'd0);
         check("err_r1_err",  32'(gotErr[1]), 32'd1);
      end
      if (nRes >= 4 && expRes == 4) begin
         check("err_r2_data", gotData[2], 32'd2);
         check("err_r3_data", gotData[3], 32'd4);
      end

      // Reset while ISSUE with three commands queued
      doReset();
      bpCmd[0] = '{4'b0000, 32'd1,  32'd2};
      bpCmd[1] = '{4'b0000, 32'd10, 32'd0};
      bpCmd[2] = '{4'b0001, 32'd20, 32'd0};
      bpCmd[3] = '{4'b0010, 32'd3,  32'd0};
      fillFive(nAcc);
      bus.res_ready = 1'b1;
      step();
      check("mid_pre_count", 32'(bus.fifo_count), 32'd3);
      check("mid_pre_rv",    32'(bus.res_valid), 32'd0);
      rst = 1'b1;
      #1;
      check("mid_rst_rv",     32'(bus.res_valid), 32'd0);
      check("mid_rst_count",  32'(bus.fifo_count), 32'd0);
      check("mid_rst_alu_op", 32'(bus.alu_op), 32'(RESET_OP));
      check("mid_rst_ready",  32'(bus.cmd_ready), 32'd1);
      step();
      rst = 1'b0;
      seen = 0;
      repeat (8) begin
         step();
         if (bus.res_valid) seen++;
      end
      check("mid_rst_no_result", seen, 32'd0);

      // err_count saturation
      doReset();
      bus.res_ready = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_op = 4'b0011; bus.cmd_p = 32'd0; bus.cmd_q = 32'd7;
      seen = 0; guard = 0;
      while (seen < 256 && guard < 3000) begin
         if (bus.res_valid) begin
            seen++;
            if (seen == 1 || seen == 254 || seen == 255 || seen == 256)
               check($sformatf("sat_at_%0d", seen), 32'(bus.err_count), (seen > 255) ? 255 : seen);
         end
         step();
         guard++;
      end
      bus.cmd_valid = 1'b0;
      check("sat_results", seen, 32'd256);
      repeat (4) step();
      check("sat_final", 32'(bus.err_count), 32'd255);

      // Randomized traffic against an in-order accumulator reference
      doReset();
      refAcc = 32'd0;
      prevHeld = 1'b0; prevData = '0; prevOp = '0; prevErr = '0;
      for (int cyc = 0; cyc < 1200; cyc++) begin
         bus.cmd_valid = ($urandom_range(0, 3) != 0);
         bus.cmd_op    = opsList[$urandom_range(0, 8)];
         bus.cmd_p     = $urandom;
         bus.cmd_q     = $urandom;
         if (bus.cmd_op == 4'b0011 && bus.cmd_p == 32'd0) bus.cmd_p = 32'd1;
         bus.res_ready = ($urandom_range(0, 2) != 0);
         if (prevHeld) begin
            check("rnd_hold_rv",   32'(bus.res_valid), 32'd1);
            check("rnd_hold_data", bus.res_data, prevData);
            check("rnd_hold_op",   32'(bus.res_op), 32'(prevOp));
            check("rnd_hold_err",  32'(bus.res_err), 32'(prevErr));
         end
         if (bus.res_valid && bus.res_ready) begin
            check("rnd_expected_pending", 32'(pending.size() != 0), 32'd1);
            if (pending.size() != 0) begin
               c = pending.pop_front();
               exp = aluEval(c.op, c.p, c.q, refAcc);
               refAcc = exp.out;
               check("rnd_data", bus.res_data, exp.out);
               check("rnd_err",  32'(bus.res_err), 32'(exp.err));
               check("rnd_op",   32'(bus.res_op), 32'(c.op));
            end
         end
         prevHeld = bus.res_valid && !bus.res_ready;
         prevData = bus.res_data; prevOp = bus.res_op; prevErr = bus.res_err;
         if (bus.cmd_valid && bus.cmd_ready)
            pending.push_back('{bus.cmd_op, bus.cmd_p, bus.cmd_q});
         step();
      end
      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b1;
      guard = 0;
      while (pending.size() != 0 && guard < 40) begin
         if (bus.res_valid) begin
            c = pending.pop_front();
            exp = aluEval(c.op, c.p, c.q, refAcc);
            refAcc = exp.out;
            check("rnd_drain_data", bus.res_data, exp.out);
            check("rnd_drain_op",   32'(bus.res_op), 32'(c.op));
         end
         step();
         guard++;
      end
      check("rnd_all_drained", pending.size(), 32'd0);
      step();
      check("rnd_end_busy", 32'(bus.busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule
